// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//
// Selects one of NSRC instruction sources and buffers the chosen words in a
// DEPTH-entry FIFO between the fetch sources and the decode stage. An
// exception word injects at top priority: it flushes the queue and becomes
// the sole entry, tagged so decode can tell it apart from fetched words.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   src_data    packed source words, source i at [i*WIDTH +: WIDTH]
//   src_sel     source index for the current push
//   src_valid   push request
//   src_ready   queue can accept a push this cycle (combinational)
//   excp_req    inject excp_data and flush the queue
//   excp_data   exception word to inject
//   flush       discard all queued words
//   out_data    head-of-queue word
//   out_excp    head word came from excp_data
//   out_valid   head word valid
//   out_ready   decode accepts the head word
//   count       current occupancy, 0..DEPTH
//   sel_err     sticky: a push used src_sel >= NSRC
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 2,
  parameter int DEPTH = 4,
  parameter int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSRC*WIDTH-1:0]   src_data,
  input  logic [SELW-1:0]         src_sel,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic                    excp_req,
  input  logic [WIDTH-1:0]        excp_data,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_excp,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNTW-1:0]         count,
  output logic                    sel_err
);

  localparam int PTRW = $clog2(DEPTH);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  // One extra bit so NSRC itself is representable when NSRC == 2**SELW.
  localparam logic [SELW:0]   NSRC_EXT = (SELW + 1)'(NSRC);

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic             mem_excp [DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;

  logic [WIDTH-1:0] sel_word;
  logic             sel_bad;
  logic             push;
  logic             pop;

  assign sel_bad = ({1'b0, src_sel} >= NSRC_EXT);

  // Out-of-range selects fall through to an all-zero word.
  always_comb begin
    // NOTE: default first so every path assigns sel_word and no latch forms.
    sel_word = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_sel == SELW'(i)) sel_word = src_data[i*WIDTH +: WIDTH];
    end
  end

  // No bypass: a full queue refuses a push even when a pop happens this cycle.
  assign src_ready = (count < FULL_CNT) && !excp_req && !flush && !rst;
  assign push      = src_valid && src_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  assign out_data  = mem_data[rd_ptr];
  assign out_excp  = mem_excp[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is cleared too, so out_data reads 0 the moment rst rises.
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_excp[i] <= 1'b0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      sel_err <= 1'b0;
    end else if (excp_req) begin
      // Exception word becomes the sole entry; same-cycle push/pop are dropped.
      mem_data[0] <= excp_data;
      mem_excp[0] <= 1'b1;
      wr_ptr      <= PTRW'(1);
      rd_ptr      <= '0;
      count       <= CNTW'(1);
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      if (push) begin
        mem_data[wr_ptr] <= sel_word;
        mem_excp[wr_ptr] <= 1'b0;
        wr_ptr           <= wr_ptr + 1'b1;
        if (sel_bad) sel_err <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Occupancy must stay within 0..DEPTH; an underflow would wrap above DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count <= FULL_CNT);
      assert (!(push && count == FULL_CNT));
    end
  end

endmodule
